latch_load_ctrl: RTL and testbench
==================================

Name: latch_load_ctrl

Overview:
Upstream controller for the 2-bit D-latch bank. It synchronises raw switch data and a raw load push-button, and debounces the button. For each debounced press it presents stable data on d and drives a clean, clock-aligned enable pulse on en. Its d and en outputs connect directly to the latch bank's D and en inputs.

Parameters:
WIDTH, 2, data width of sw/d; must match the latch bank width.
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a press or a release; minimum 1.
EN_PULSE_CYCLES, 1, number of clocks en stays high per accepted press; minimum 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
sw  input  WIDTH  raw switch data, asynchronous to clk.
load_btn  input  1  raw load push-button, active-high, asynchronous and bouncy.
d  output  WIDTH  registered data for the latch D inputs.
en  output  1  registered latch enable.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - Asynchronous assert on rst_n=0 sets state=IDLE and clears all counters.
  - Both synchroniser stages are cleared to 0; d=0, en=0, busy=0.
  - Deassertion is taken synchronously: first update on the next rising edge.
  - Reset mid-operation aborts immediately. en drops to 0 within the reset and no partial pulse resumes afterwards.
- Synchronisers: sw and load_btn each pass through two flops, giving sw_s and btn_s. The FSM uses only sw_s and btn_s.
- FSM states: IDLE, DEBOUNCE, LOAD, WAIT_RELEASE. A single counter cnt (width clog2 of the max of both parameters, plus 1) serves every state.
  - IDLE: if btn_s=1, go to DEBOUNCE with cnt=0; otherwise stay.
  - DEBOUNCE: if btn_s=0, go to IDLE (glitch rejected). Otherwise cnt++. The sample that makes the count of consecutive highs equal DEBOUNCE_CYCLES moves to LOAD, captures d<=sw_s on the same edge, and sets cnt=0.
  - LOAD: en=1. cnt++ each clock. After EN_PULSE_CYCLES clocks in LOAD, go to WAIT_RELEASE with cnt=0.
  - WAIT_RELEASE: en=0. If btn_s=1, set cnt=0. If btn_s=0, cnt++. The sample that makes the count of consecutive lows equal DEBOUNCE_CYCLES returns to IDLE.
- Outputs:
  - en is a registered Moore output, high exactly while state=LOAD.
  - d changes only on the edge that enters LOAD, so it is stable before and throughout en and held afterwards.
  - busy = (state != IDLE), registered.
- Latency: with edge 1 the first edge that samples raw load_btn high (clean press), en is high after edge DEBOUNCE_CYCLES+3. With defaults, en is high after edge 7 and low after edge 8.
- Boundary conditions:
  - sw changing during DEBOUNCE: the value captured is sw_s at the LOAD-entry edge.
  - sw changing during LOAD or WAIT_RELEASE: ignored.
  - A held button produces exactly one pulse; a new pulse requires a debounced release first.
  - Bounce during release restarts the release count.
  - DEBOUNCE_CYCLES=1: one high sample in DEBOUNCE suffices.

Optional Feature:
Macro LOAD_COUNT_EN.
- Defined:
  - Adds output load_count, 8 bits, reset 0.
  - Increments on each entry into LOAD, wraps 255 to 0.
  - Cleared asynchronously by rst_n.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst_n=0 with sw=2'b11 and load_btn=1 -> d=2'b00, en=0, busy=0. Release reset at a clean edge, then hold load_btn=1 -> exactly one en pulse.
2. Clean press, defaults, sw=2'b10 held from before the press -> en high only after edge 7, d=2'b10 from edge 7 onward, busy falls 4 clocks after the button is released.
3. Bounce: load_btn toggles 1,0,1,0 on consecutive clocks, then stays 0 -> no en pulse, busy returns to 0, d unchanged.
4. Held button for 50 clocks with sw changing 01 -> 11 after the pulse -> exactly one en pulse, d stays at 01.
5. EN_PULSE_CYCLES=3, DEBOUNCE_CYCLES=1, sw=2'b01 -> en high for exactly 3 consecutive clocks, d=2'b01. With LOAD_COUNT_EN defined, 256 presses -> load_count=0.
6. Reset asserted while en=1 (mid-LOAD) -> en=0 and d=0 immediately. After release with the button held, no pulse appears until the debounce completes afresh.

Source files
------------

// File: rtl/latch_load_ctrl.sv
// latch_load_ctrl
// Upstream controller for the D-latch bank: synchronises raw switch data and a
// raw load button, debounces the button, and for each accepted press presents
// stable data on d together with a clean, clock-aligned enable pulse on en.
// Optional feature: define LOAD_COUNT_EN to add the 8-bit load_count output.
module latch_load_ctrl #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int EN_PULSE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw,
   input  logic             load_btn,
   output logic [WIDTH-1:0] d,
   output logic             en,
   output logic             busy
`ifdef LOAD_COUNT_EN
   ,
   output logic [7:0]       load_count
`endif
);

   // One counter serves every state, so it is sized for the larger limit.
   localparam int CNT_MAX = (DEBOUNCE_CYCLES > EN_PULSE_CYCLES) ? DEBOUNCE_CYCLES
                                                                : EN_PULSE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(EN_PULSE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      LOAD,
      WAIT_RELEASE
   } state_t;

   logic [WIDTH-1:0] r_sw_s1;
   logic [WIDTH-1:0] r_sw_s2;
   logic             r_btn_s1;
   logic             r_btn_s2;

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_next_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_enter_load;

   logic [WIDTH-1:0] r_d;
   logic             r_en;
   logic             r_busy;

   // Two-flop synchronisers for the asynchronous switch data and button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
         r_btn_s1 <= 1'b0;
         r_btn_s2 <= 1'b0;
      end else begin
         // NOTE: non-blocking so each stage samples its predecessor's pre-edge
         // value; blocking assignments would collapse the chain into one flop.
         r_sw_s1  <= sw;
         r_sw_s2  <= r_sw_s1;
         r_btn_s1 <= load_btn;
         r_btn_s2 <= r_btn_s1;
      end
   end

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // Next-state and counter logic; the counter counts consecutive qualifying samples.
   always_comb begin
      // NOTE: defaults first so every path assigns every signal; a branch that
      // left one unassigned would infer a latch.
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_enter_load = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_btn_s2) begin
               w_next_state = DEBOUNCE;
               w_next_cnt   = '0;
            end
         end
         DEBOUNCE: begin
            if (!r_btn_s2) begin
               // Glitch rejected: any low sample aborts the press.
               w_next_state = IDLE;
               w_next_cnt   = '0;
            end else if (w_cnt_inc == DEB_LAST) begin
               w_next_state = LOAD;
               w_next_cnt   = '0;
               w_enter_load = 1'b1;
            end else begin
               w_next_cnt   = w_cnt_inc;
            end
         end
         LOAD: begin
            if (w_cnt_inc == PULSE_LAST) begin
               w_next_state = WAIT_RELEASE;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt   = w_cnt_inc;
            end
         end
         WAIT_RELEASE: begin
            if (r_btn_s2) begin
               // Bounce during release restarts the low-sample count.
               w_next_cnt   = '0;
            end else if (w_cnt_inc == DEB_LAST) begin
               w_next_state = IDLE;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt   = w_cnt_inc;
            end
         end
         default: begin
            w_next_state = IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // Registered outputs: en and busy track the state being entered, d is
   // captured only on the edge that enters LOAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d    <= '0;
         r_en   <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         if (w_enter_load) begin
            r_d <= r_sw_s2;
         end
         r_en   <= (w_next_state == LOAD);
         r_busy <= (w_next_state != IDLE);
      end
   end

   assign d    = r_d;
   assign en   = r_en;
   assign busy = r_busy;

`ifdef LOAD_COUNT_EN
   logic [7:0] r_load_count;

   // Counts accepted presses (entries into LOAD), wrapping at 255.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_count <= 8'd0;
      end else if (w_enter_load) begin
         r_load_count <= r_load_count + 8'd1;
      end
   end

   assign load_count = r_load_count;
`endif

endmodule

// File: tb/tb_latch_load_ctrl.sv
// tb_latch_load_ctrl
// Self-checking bench for latch_load_ctrl. Two instances share stimulus: one
// with default parameters, one with DEBOUNCE_CYCLES=1, EN_PULSE_CYCLES=3.
// The reference model counts runs of synchronised button samples rather than
// tracking controller states. Define LOAD_COUNT_EN to also check load_count.
module tb_latch_load_ctrl;

   logic       clk;
   logic       rst_n;
   logic [1:0] sw;
   logic       load_btn;

   logic [1:0] d0, d1;
   logic       en0, en1;
   logic       busy0, busy1;
`ifdef LOAD_COUNT_EN
   logic [7:0] lc0, lc1;
`endif

   latch_load_ctrl #(
      .WIDTH           (2),
      .DEBOUNCE_CYCLES (4),
      .EN_PULSE_CYCLES (1)
   ) dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw         (sw),
      .load_btn   (load_btn),
      .d          (d0),
      .en         (en0),
      .busy       (busy0)
`ifdef LOAD_COUNT_EN
      ,
      .load_count (lc0)
`endif
   );

   latch_load_ctrl #(
      .WIDTH           (2),
      .DEBOUNCE_CYCLES (1),
      .EN_PULSE_CYCLES (3)
   ) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw         (sw),
      .load_btn   (load_btn),
      .d          (d1),
      .en         (en1),
      .busy       (busy1)
`ifdef LOAD_COUNT_EN
      ,
      .load_count (lc1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int         dc [2] = '{4, 1};
   int         ep [2] = '{1, 3};
   bit         armed [2];       // ready to accept a new press
   int         hi_run [2];      // consecutive high samples while armed
   int         lo_run [2];      // consecutive low samples after a pulse
   int         pulse_left [2];  // clocks of en still to come
   logic [1:0] m_d [2];
   int         m_count [2];
   logic       mb1, mb2;
   logic [1:0] ms1, ms2;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         pulses0, pulses1;
   logic       prev_en0, prev_en1;
   int         found, hi_cnt, first_k, last_k, hold;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         armed[m]      = 1'b1;
         hi_run[m]     = 0;
         lo_run[m]     = 0;
         pulse_left[m] = 0;
         m_d[m]        = 2'b00;
         m_count[m]    = 0;
      end
      mb1 = 1'b0; mb2 = 1'b0;
      ms1 = 2'b00; ms2 = 2'b00;
   endtask

   // Advance one instance by one clock using the synchronised samples.
   task automatic model_step(input int m);
      if (pulse_left[m] > 0) begin
         pulse_left[m]--;
         if (pulse_left[m] == 0) lo_run[m] = 0;
      end else if (!armed[m]) begin
         if (mb2) begin
            lo_run[m] = 0;
         end else begin
            lo_run[m]++;
            if (lo_run[m] == dc[m]) begin
               armed[m]  = 1'b1;
               hi_run[m] = 0;
            end
         end
      end else if (mb2) begin
         hi_run[m]++;
         // First high sample is the one that leaves idle, then dc more.
         if (hi_run[m] == dc[m] + 1) begin
            armed[m]      = 1'b0;
            hi_run[m]     = 0;
            pulse_left[m] = ep[m];
            m_d[m]        = ms2;
            m_count[m]    = (m_count[m] + 1) % 256;
         end
      end else begin
         hi_run[m] = 0;
      end
   endtask

   task automatic compare_all();
      check("en0",   en0,   pulse_left[0] > 0);
      check("en1",   en1,   pulse_left[1] > 0);
      check("busy0", busy0, !(armed[0] && hi_run[0] == 0));
      check("busy1", busy1, !(armed[1] && hi_run[1] == 0));
      check("d0",    d0,    m_d[0]);
      check("d1",    d1,    m_d[1]);
`ifdef LOAD_COUNT_EN
      check("lc0",   lc0,   m_count[0]);
      check("lc1",   lc1,   m_count[1]);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_n) begin
         for (int m = 0; m < 2; m++) model_step(m);
         mb2 = mb1; mb1 = load_btn;
         ms2 = ms1; ms1 = sw;
      end
      cyc++;
      compare_all();
      if (en0 && !prev_en0) pulses0++;
      if (en1 && !prev_en1) pulses1++;
      prev_en0 = en0;
      prev_en1 = en1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      prev_en0 = 1'b0;
      prev_en1 = 1'b0;
      compare_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1. Reset with inputs active, then a held press gives one pulse.
      rst_n = 1'b0; sw = 2'b11; load_btn = 1'b1;
      model_reset();
      prev_en0 = 1'b0; prev_en1 = 1'b0;
      ticks(3);
      check("t1_rst_d0", d0, 2'b00);
      check("t1_rst_en0", en0, 1'b0);
      check("t1_rst_busy0", busy0, 1'b0);
      check("t1_rst_en1", en1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses0 = 0; pulses1 = 0;
      ticks(30);
      check("t1_pulses0", pulses0, 1);
      check("t1_pulses1", pulses1, 1);
      load_btn = 1'b0;
      ticks(12);
      check("t1_idle_busy0", busy0, 1'b0);
      check("t1_idle_busy1", busy1, 1'b0);

      // 2. Clean press with sw=10 settled beforehand: latency and release timing.
      sw = 2'b10;
      ticks(10);
      load_btn = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 6) begin
            check("t2_en0_k6", en0, 1'b0);
            check("t2_d0_k6", d0, 2'b11);
         end
         if (k == 7) begin
            check("t2_en0_k7", en0, 1'b1);
            check("t2_d0_k7", d0, 2'b10);
         end
         if (k == 8) check("t2_en0_k8", en0, 1'b0);
         if (k == 3) check("t2_en1_k3", en1, 1'b0);
         if (k >= 4 && k <= 6) check("t2_en1_hi", en1, 1'b1);
         if (k == 7) check("t2_en1_k7", en1, 1'b0);
      end
      load_btn = 1'b0;
      for (int r = 1; r <= 10; r++) begin
         tick();
         if (r == 5) check("t2_busy0_r5", busy0, 1'b1);
         if (r == 6) check("t2_busy0_r6", busy0, 1'b0);
         if (r == 2) check("t2_busy1_r2", busy1, 1'b1);
         if (r == 3) check("t2_busy1_r3", busy1, 1'b0);
      end
      check("t2_d0_hold", d0, 2'b10);

      // 3. Bounce 1,0,1,0 then low: rejected by both instances.
      pulses0 = 0; pulses1 = 0;
      load_btn = 1'b1; tick();
      load_btn = 1'b0; tick();
      load_btn = 1'b1; tick();
      load_btn = 1'b0; tick();
      ticks(12);
      check("t3_pulses0", pulses0, 0);
      check("t3_pulses1", pulses1, 0);
      check("t3_busy0", busy0, 1'b0);
      check("t3_d0", d0, 2'b10);

      // 4. Button held 50 clocks, sw changes after the pulse.
      sw = 2'b01;
      ticks(10);
      pulses0 = 0; pulses1 = 0;
      load_btn = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         if (k == 15) sw = 2'b11;
         tick();
      end
      check("t4_pulses0", pulses0, 1);
      check("t4_pulses1", pulses1, 1);
      check("t4_d0", d0, 2'b01);
      check("t4_d1", d1, 2'b01);
      load_btn = 1'b0;
      ticks(12);

      // 5. Three-clock pulse on the DEBOUNCE_CYCLES=1 instance.
      sw = 2'b01;
      ticks(10);
      load_btn = 1'b1;
      hi_cnt = 0; first_k = -1; last_k = -1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (en1) begin
            hi_cnt++;
            if (first_k < 0) first_k = k;
            last_k = k;
         end
      end
      check("t5_en1_len", hi_cnt, 3);
      check("t5_en1_span", last_k - first_k + 1, 3);
      check("t5_d1", d1, 2'b01);
      load_btn = 1'b0;
      ticks(12);

      // 6. Reset mid-LOAD, then a fresh full debounce with the button held.
      sw = 2'b10;
      ticks(4);
      load_btn = 1'b1;
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         tick();
         if (en0) found = 1;
      end
      check("t6_en0_seen", found, 1);
      #2;
      async_reset();
      check("t6_rst_en0", en0, 1'b0);
      check("t6_rst_d0", d0, 2'b00);
      check("t6_rst_en1", en1, 1'b0);
      check("t6_rst_d1", d1, 2'b00);
      ticks(2);
      @(negedge clk);
      rst_n = 1'b1;
      pulses0 = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 6) check("t6_en0_k6", en0, 1'b0);
         if (k == 7) check("t6_en0_k7", en0, 1'b1);
      end
      check("t6_pulses0", pulses0, 1);
      load_btn = 1'b0;
      ticks(12);

`ifdef LOAD_COUNT_EN
      // 256 accepted presses wrap the counter back to zero.
      #2;
      async_reset();
      @(negedge clk);
      rst_n = 1'b1;
      pulses0 = 0;
      for (int p = 0; p < 256; p++) begin
         load_btn = 1'b1;
         ticks(8);
         load_btn = 1'b0;
         ticks(8);
      end
      check("lc_pulses0", pulses0, 256);
      check("lc0_wrap", lc0, 8'd0);
      check("lc1_wrap", lc1, 8'd0);
`endif

      // Randomised button hold lengths, switch changes and occasional resets.
      hold = 0;
      for (int i = 0; i < 800; i++) begin
         if (hold == 0) begin
            load_btn = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
         end
         hold--;
         if ($urandom_range(0, 3) == 0) sw = 2'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            #2;
            async_reset();
            @(negedge clk);
            rst_n = 1'b1;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
